// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: sequences the period/duty/direction registers of one PWM
// channel. Targets arrive over a valid/ready handshake. Applied duty ramps
// toward the target by a programmable step, and outputs change only on
// period_end pulses so the PWM core never sees a mid-period update.
// A direction reversal ramps duty to 0, waits DEAD_PERIODS full periods at
// duty 0, flips motor_dir, and then ramps back up.
module pwm_ramp_ctrl #(
    parameter int REG_WIDTH    = 32,
    parameter int DEAD_PERIODS = 4
) (
    input  logic                 pwm_clk,
    input  logic                 pwm_rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [REG_WIDTH-1:0] cmd_period,
    input  logic [REG_WIDTH-1:0] cmd_duty,
    input  logic                 cmd_dir,
    input  logic [REG_WIDTH-1:0] cmd_step,
    input  logic                 period_end,
    output logic [REG_WIDTH-1:0] pwm_period,
    output logic [REG_WIDTH-1:0] pwm_duty,
    output logic                 motor_dir,
    output logic                 busy,
    output logic                 at_target
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RAMP,
        ST_DEAD
    } state_e;

    localparam int                CNT_W     = (DEAD_PERIODS > 0) ? $clog2(DEAD_PERIODS + 1) : 1;
    localparam logic [CNT_W-1:0]  DEAD_INIT = CNT_W'(DEAD_PERIODS);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    state_e                 state_q, state_d;
    logic [REG_WIDTH-1:0]   period_q, period_d;
    logic [REG_WIDTH-1:0]   duty_q, duty_d;
    logic                   dir_q, dir_d;
    logic [REG_WIDTH-1:0]   tgt_period_q, tgt_period_d;
    logic [REG_WIDTH-1:0]   tgt_duty_q, tgt_duty_d;
    logic                   tgt_dir_q, tgt_dir_d;
    logic [REG_WIDTH-1:0]   tgt_step_q, tgt_step_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   ready_q, ready_d;
    logic                   busy_q, busy_d;
    logic                   at_target_q, at_target_d;

    logic                   xfer;
    logic [REG_WIDTH-1:0]   cmd_duty_clamped;
    logic [REG_WIDTH-1:0]   duty_clamped;

    // One step of cur toward dst; step==0 means jump straight to dst.
    // Only the distance is compared against step, so cur+step never
    // overshoots dst and the sum cannot wrap.
    function automatic logic [REG_WIDTH-1:0] step_toward(
        input logic [REG_WIDTH-1:0] cur,
        input logic [REG_WIDTH-1:0] dst,
        input logic [REG_WIDTH-1:0] step
    );
        logic [REG_WIDTH-1:0] res;
        res = dst;
        if (step != '0) begin
            if (cur < dst) begin
                if (dst - cur > step) res = cur + step;
            end else if (cur > dst) begin
                if (cur - dst > step) res = cur - step;
            end
        end
        return res;
    endfunction

    // Next-state logic: period_end update from the old targets, then handshake.
    always_comb begin
        // NOTE: every _d starts from its _q so paths that do not assign it hold
        // the value instead of inferring a latch.
        state_d      = state_q;
        period_d     = period_q;
        duty_d       = duty_q;
        dir_d        = dir_q;
        tgt_period_d = tgt_period_q;
        tgt_duty_d   = tgt_duty_q;
        tgt_dir_d    = tgt_dir_q;
        tgt_step_d   = tgt_step_q;
        cnt_d        = cnt_q;

        xfer             = cmd_valid && (state_q != ST_DEAD);
        cmd_duty_clamped = (cmd_duty > cmd_period) ? cmd_period : cmd_duty;
        duty_clamped     = (duty_q > tgt_period_q) ? tgt_period_q : duty_q;

        if (period_end) begin
            case (state_q)
                ST_RAMP: begin
                    period_d = tgt_period_q;
                    if (tgt_dir_q != dir_q) begin
                        if (duty_q == '0) begin
                            if (DEAD_PERIODS == 0) begin
                                dir_d = tgt_dir_q;
                            end else begin
                                state_d = ST_DEAD;
                                cnt_d   = DEAD_INIT;
                            end
                        end else begin
                            duty_d = step_toward(duty_clamped, '0, tgt_step_q);
                        end
                    end else begin
                        duty_d = step_toward(duty_clamped, tgt_duty_q, tgt_step_q);
                        if (duty_d == tgt_duty_q) state_d = ST_IDLE;
                    end
                end
                ST_DEAD: begin
                    duty_d = '0;
                    cnt_d  = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        dir_d   = tgt_dir_q;
                        state_d = ST_RAMP;
                    end
                end
                default: ;
            endcase
        end

        // A new command only replaces the targets; the applied values above
        // were already computed from the old ones. A dead-time entered on
        // this same edge still runs to completion.
        if (xfer) begin
            tgt_period_d = cmd_period;
            tgt_duty_d   = cmd_duty_clamped;
            tgt_dir_d    = cmd_dir;
            tgt_step_d   = cmd_step;
            if (state_d != ST_DEAD) begin
                state_d = (period_d == cmd_period && duty_d == cmd_duty_clamped &&
                           dir_d == cmd_dir) ? ST_IDLE : ST_RAMP;
            end
        end

        ready_d     = (state_d != ST_DEAD);
        busy_d      = (state_d != ST_IDLE);
        at_target_d = (duty_d == tgt_duty_d) && (period_d == tgt_period_d) &&
                      (dir_d == tgt_dir_d);
    end

    // State and registered outputs; synchronous reset aborts any sequence.
    always_ff @(posedge pwm_clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (pwm_rst) begin
            state_q      <= ST_IDLE;
            period_q     <= '0;
            duty_q       <= '0;
            dir_q        <= 1'b0;
            tgt_period_q <= '0;
            tgt_duty_q   <= '0;
            tgt_dir_q    <= 1'b0;
            tgt_step_q   <= '0;
            cnt_q        <= '0;
            ready_q      <= 1'b1;
            busy_q       <= 1'b0;
            at_target_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            period_q     <= period_d;
            duty_q       <= duty_d;
            dir_q        <= dir_d;
            tgt_period_q <= tgt_period_d;
            tgt_duty_q   <= tgt_duty_d;
            tgt_dir_q    <= tgt_dir_d;
            tgt_step_q   <= tgt_step_d;
            cnt_q        <= cnt_d;
            ready_q      <= ready_d;
            busy_q       <= busy_d;
            at_target_q  <= at_target_d;
        end
    end

    assign cmd_ready  = ready_q;
    assign pwm_period = period_q;
    assign pwm_duty   = duty_q;
    assign motor_dir  = dir_q;
    assign busy       = busy_q;
    assign at_target  = at_target_q;

endmodule

// File: doc/pwm_ramp_ctrl.md
Name: pwm_ramp_ctrl

Overview:
- Sequences the duty/period/direction registers that drive one PWM generator channel of the robot motor driver.
- Accepts target commands from the bus-side register logic over a valid/ready handshake.
- Ramps applied duty toward the target by a programmable step once per PWM period, and updates outputs only at period boundaries (glitch-free).
- Handles direction reversal: ramp down to 0, dead-time, flip direction, ramp up.

Parameters:
REG_WIDTH, 32, width of period/duty/step values (matches PWM core register width)
DEAD_PERIODS, 4, number of full PWM periods held at duty 0 before motor_dir flips (0 = no dead-time)

Ports:
pwm_clk  in  1  single clock for the block
pwm_rst  in  1  synchronous reset, active-high
cmd_valid  in  1  new target command present
cmd_ready  out  1  block can accept command
cmd_period  in  REG_WIDTH  target PWM period
cmd_duty  in  REG_WIDTH  target duty magnitude
cmd_dir  in  1  target motor direction
cmd_step  in  REG_WIDTH  duty increment per period; 0 = jump directly to target
period_end  in  1  one-cycle pulse from PWM counter on wrap (counter == period)
pwm_period  out  REG_WIDTH  applied period to PWM core
pwm_duty  out  REG_WIDTH  applied duty to PWM core
motor_dir  out  1  applied H-bridge direction
busy  out  1  state != IDLE
at_target  out  1  applied values equal latched target

Behaviour:
- Reset: on pwm_clk edge with pwm_rst=1, all outputs and internal registers clear: pwm_period=0, pwm_duty=0, motor_dir=0, targets=0, dead counter=0, state=IDLE. cmd_ready=1, busy=0, at_target=1 in the cycle after reset. A reset mid-ramp or mid-dead-time aborts the sequence immediately. period_end is ignored while pwm_rst=1.
- Handshake: transfer occurs when cmd_valid && cmd_ready. cmd_ready = (state != DEAD).
  - On transfer, latch tgt_period=cmd_period, tgt_duty=min(cmd_duty, cmd_period), tgt_dir=cmd_dir, tgt_step=cmd_step.
  - A later transfer overwrites earlier targets; no queueing.
  - A transfer moves IDLE->RAMP in the same cycle unless the new target equals the applied values.
- Update timing: pwm_period, pwm_duty and motor_dir change only on cycles where period_end=1 (except reset). Each update uses the targets latched before that edge. If a transfer and period_end coincide, period_end uses the old targets and the new targets take effect at the next period_end.
- States:
  - IDLE: applied values equal targets. period_end causes no change.
  - RAMP: on each period_end:
    - pwm_period <= tgt_period.
    - If tgt_dir != motor_dir: duty moves toward 0. If pwm_duty == 0 at this pulse, go to DEAD with cnt=DEAD_PERIODS; if DEAD_PERIODS=0, instead flip motor_dir on this pulse and stay in RAMP.
    - Else: duty moves toward tgt_duty. Enter IDLE when the new duty == tgt_duty and pwm_period == tgt_period.
  - DEAD: pwm_duty held 0. Each period_end decrements cnt. On the pulse where cnt goes 1->0, motor_dir <= tgt_dir and the state becomes RAMP; duty starts rising on the following period_end.
- Step arithmetic: unsigned, no wrap.
  - Up: if tgt - duty <= step then duty = tgt, else duty + step.
  - Down to d: if duty - d <= step then duty = d, else duty - step.
  - step=0: duty takes the endpoint value in a single period_end.
- Period shrink: if the current pwm_duty > new tgt_period, duty is clamped to tgt_period on the same period_end before stepping continues.
- at_target = (pwm_duty==tgt_duty && pwm_period==tgt_period && motor_dir==tgt_dir), registered output of the comparison.
- Latency: command accepted at cycle N affects outputs at the first period_end strictly after N.

Test Plan:
- Reset then cmd(period=1000, duty=300, dir=0, step=100), period_end every 1001 clk -> pwm_duty 100,200,300 on successive pulses; IDLE, busy=0, at_target=1 after the 3rd pulse; pwm_period=1000 from the 1st pulse.
- From duty 300 dir 0, cmd(duty=200, dir=1, step=100), DEAD_PERIODS=4 -> duty 200,100,0; then 4 pulses at 0 with cmd_ready=0; motor_dir=1 on the 4th dead pulse; then duty 100,200.
- cmd duty=1500 with period=1000, step=0 -> pwm_duty=1000 at the first period_end; at_target=1.
- cmd issued on the same cycle as period_end -> that pulse's update reflects the old target; the new target is applied at the next pulse; no output change between pulses.
- Assert pwm_rst during DEAD (cnt=2) -> next cycle: pwm_duty=0, motor_dir=0, pwm_period=0, cmd_ready=1, busy=0; a following period_end causes no change.
- step=250, duty 0->900, REG_WIDTH=8 build with period=255, duty 200, step 100 -> 100,200 (saturate, no overflow); 32-bit run: 250,500,750,900.
